// File: rtl/precode_lanes_pkg.sv
// Shared constants and lane-extraction helper for the 1/(1+D) modulo precoder.
package precode_pkg;
  localparam logic MODE_BYPASS  = 1'b0;
  localparam logic MODE_PRECODE = 1'b1;
  localparam int   DIR_TX       = 0;
  localparam int   DIR_RX       = 1;

  // Widest lane and beat the helper handles; callers cast to their own width.
  localparam int LANE_W_MAX = 8;
  localparam int DATA_W_MAX = 256;

  typedef logic [LANE_W_MAX-1:0] lane_max_t;
  typedef logic [DATA_W_MAX-1:0] data_max_t;

  function automatic lane_max_t lane_get(input data_max_t data, input int i, input int bits);
    return lane_max_t'(data >> (i * bits));
  endfunction
endpackage

// File: rtl/precode_lanes_if.sv
// Stream and configuration bundle between the precoder and its neighbours.
interface precode_lanes_if #(
  parameter int BITS  = 2,
  parameter int LANES = 4
);
  logic                  cfg_mode;
  logic                  cfg_load;
  logic [LANES*BITS-1:0] in_data;
  logic                  in_sof;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*BITS-1:0] out_data;
  logic                  out_sof;
  logic                  out_valid;
  logic                  out_ready;
  logic                  mode_act;

  modport master (
    output cfg_mode, cfg_load, in_data, in_sof, in_valid, out_ready,
    input  in_ready, out_data, out_sof, out_valid, mode_act
  );

  modport slave (
    input  cfg_mode, cfg_load, in_data, in_sof, in_valid, out_ready,
    output in_ready, out_data, out_sof, out_valid, mode_act
  );
endinterface

// File: rtl/precode_lanes_skid.sv
// Two-entry skid buffer; ready is registered so upstream never sees out_ready combinationally.
module precode_skid #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] wr_data,
  input  logic         wr_valid,
  output logic         wr_ready,
  output logic [W-1:0] rd_data,
  output logic         rd_valid,
  input  logic         rd_ready
);
  logic [1:0][W-1:0] ent;
  logic              wp, rp;
  logic [1:0]        cnt, cnt_nxt;
  logic              push, pop;

  assign push     = wr_valid & wr_ready;
  assign pop      = rd_valid & rd_ready;
  assign cnt_nxt  = cnt + 2'(push) - 2'(pop);
  assign rd_valid = (cnt != 2'd0);
  assign rd_data  = ent[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent      <= '0;
      wp       <= 1'b0;
      rp       <= 1'b0;
      cnt      <= 2'd0;
      wr_ready <= 1'b0;
    end else begin
      if (push) begin
        ent[wp] <= wr_data;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt      <= cnt_nxt;
      wr_ready <= (cnt_nxt != 2'd2);
    end
  end
endmodule

// File: rtl/precode_lanes.sv
// Multi-lane 1/(1+D) mod 2^BITS precoder (TX) or decoder (RX) with frame-aligned mode switching.
module precode_lanes
  import precode_pkg::*;
#(
  parameter int BITS     = 2,
  parameter int LANES    = 4,
  parameter int DIR      = DIR_TX,
  parameter bit MODE_RST = MODE_PRECODE
) (
  input logic            clk,
  input logic            rst,
  precode_lanes_if.slave bus
);
  localparam int W = LANES * BITS;

  logic                        in_ready, accept, sof_acc;
  logic                        pend, pend_eff, mode_act, mode_use;
  logic [BITS-1:0]             mem, base, prev, mem_nxt;
  logic [LANES-1:0][BITS-1:0]  x, y;
  logic [W:0]                  rd_data;

  assign accept   = bus.in_valid & in_ready;
  assign sof_acc  = accept & bus.in_sof;
  // A load coinciding with an accepted sof already governs that beat.
  assign pend_eff = bus.cfg_load ? bus.cfg_mode : pend;
  assign mode_use = sof_acc ? pend_eff : mode_act;
  assign base     = bus.in_sof ? '0 : mem;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign x[i] = BITS'(lane_get(data_max_t'(bus.in_data), i, BITS));
  end

  // Lane 0 is earliest; each lane's predecessor is the previous lane (or mem).
  always_comb begin
    y    = '0;
    prev = base;
    for (int i = 0; i < LANES; i++) begin
      if (DIR == DIR_TX) begin
        y[i] = (mode_use == MODE_PRECODE) ? x[i] - prev : x[i];
        prev = y[i];
      end else begin
        y[i] = (mode_use == MODE_PRECODE) ? x[i] + prev : x[i];
        prev = x[i];
      end
    end
  end

  assign mem_nxt = (mode_use == MODE_BYPASS) ? '0 :
                   (DIR == DIR_TX) ? y[LANES-1] : x[LANES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= MODE_RST;
      mode_act <= MODE_RST;
      mem      <= '0;
    end else begin
      pend <= pend_eff;
      if (sof_acc) mode_act <= pend_eff;
      if (accept)  mem      <= mem_nxt;
    end
  end

  precode_skid #(.W(W + 1)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .wr_data  ({bus.in_sof, y}),
    .wr_valid (bus.in_valid),
    .wr_ready (in_ready),
    .rd_data  (rd_data),
    .rd_valid (bus.out_valid),
    .rd_ready (bus.out_ready)
  );

  assign {bus.out_sof, bus.out_data} = rd_data;
  assign bus.in_ready = in_ready;
  assign bus.mode_act = mode_act;
endmodule

// File: tb/tb_precode_lanes.sv
// Bench for precode_lanes: TX and RX instances, arithmetic reference model, directed and random traffic.
module tb_precode_lanes;
  localparam int BITS  = 2;
  localparam int LANES = 4;
  localparam int W     = BITS * LANES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  precode_lanes_if #(.BITS(BITS), .LANES(LANES)) tx_if ();
  precode_lanes_if #(.BITS(BITS), .LANES(LANES)) rx_if ();

  precode_lanes #(.BITS(BITS), .LANES(LANES), .DIR(0), .MODE_RST(1'b1)) u_tx (
    .clk(clk), .rst(rst), .bus(tx_if.slave));
  precode_lanes #(.BITS(BITS), .LANES(LANES), .DIR(1), .MODE_RST(1'b1)) u_rx (
    .clk(clk), .rst(rst), .bus(rx_if.slave));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: symbols as integers mod M, predecessor is the previous output (TX) or input (RX).
  function automatic void pc_model(input int dir, input bit mode, input int mem_in,
                                   input logic [W-1:0] x, output logic [W-1:0] y, output int mem_out);
    int m = 1 << BITS;
    int pred = mem_in;
    int xi, yi;
    y = '0;
    mem_out = 0;
    for (int i = 0; i < LANES; i++) begin
      xi = int'((x >> (i * BITS)) & W'(m - 1));
      if (!mode)         yi = xi;
      else if (dir == 0) yi = (xi - pred + m) % m;
      else               yi = (xi + pred) % m;
      y[i*BITS +: BITS] = yi[BITS-1:0];
      if (mode) pred = (dir == 0) ? yi : xi;
    end
    if (mode) mem_out = pred;
  endfunction

  logic [W:0] expq [2][$];
  logic [W:0] outs [2][$];
  bit         m_act [2];
  bit         m_pend [2];
  int         m_mem [2];
  bit         held_v [2];
  logic [W:0] held [2];
  bit         collect = 1'b0;
  int         since = 0;
  int         rmode = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) since <= 0;
    else     since <= since + 1;
  end

  task automatic model_clear();
    for (int w = 0; w < 2; w++) begin
      expq[w].delete();
      m_act[w]  = 1'b1;
      m_pend[w] = 1'b1;
      m_mem[w]  = 0;
      held_v[w] = 1'b0;
    end
  endtask

  always @(posedge rst) model_clear();

  task automatic mon(input int w, input logic iv, input logic ir, input logic isof,
                     input logic [W-1:0] id, input logic ld, input logic md,
                     input logic ov, input logic ordy, input logic osof,
                     input logic [W-1:0] od, input logic ma);
    logic [W:0] e;
    logic [W-1:0] y;
    bit pe;
    string tag;
    tag = (w == 0) ? "tx" : "rx";
    if (rst) begin
      model_clear();
      return;
    end
    chk({tag, "_mode_act"}, 32'(ma), 32'(m_act[w]));
    if (since >= 1) chk({tag, "_in_ready"}, 32'(ir), 32'(expq[w].size() < 2));
    chk({tag, "_out_valid"}, 32'(ov), 32'(expq[w].size() != 0));
    if (ov && held_v[w]) chk({tag, "_stall_stable"}, 32'({osof, od}), 32'(held[w]));
    held_v[w] = ov && !ordy;
    held[w]   = {osof, od};
    if (ov && ordy && expq[w].size() != 0) begin
      e = expq[w].pop_front();
      chk({tag, "_out_beat"}, 32'({osof, od}), 32'(e));
      if (collect) outs[w].push_back({osof, od});
    end
    if (iv && ir) begin
      pe = ld ? md : m_pend[w];
      if (isof) begin
        m_act[w] = pe;
        m_mem[w] = 0;
      end
      pc_model(w, m_act[w], m_mem[w], id, y, m_mem[w]);
      expq[w].push_back({isof, y});
    end
    if (ld) m_pend[w] = md;
  endtask

  always @(negedge clk) begin
    mon(0, tx_if.in_valid, tx_if.in_ready, tx_if.in_sof, tx_if.in_data, tx_if.cfg_load,
        tx_if.cfg_mode, tx_if.out_valid, tx_if.out_ready, tx_if.out_sof, tx_if.out_data, tx_if.mode_act);
    mon(1, rx_if.in_valid, rx_if.in_ready, rx_if.in_sof, rx_if.in_data, rx_if.cfg_load,
        rx_if.cfg_mode, rx_if.out_valid, rx_if.out_ready, rx_if.out_sof, rx_if.out_data, rx_if.mode_act);
  end

  always @(posedge clk) begin
    #1;
    tx_if.out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
    rx_if.out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
  end

  task automatic drive(input int w, input logic v, input logic [W-1:0] d, input logic sof,
                       input logic ld, input logic md);
    if (w == 0) begin
      tx_if.in_valid = v; tx_if.in_data = d; tx_if.in_sof = sof;
      tx_if.cfg_load = ld; tx_if.cfg_mode = md;
    end else begin
      rx_if.in_valid = v; rx_if.in_data = d; rx_if.in_sof = sof;
      rx_if.cfg_load = ld; rx_if.cfg_mode = md;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(input int w, input logic [W-1:0] d, input logic sof,
                      input logic ld, input logic md);
    bit acc = 1'b0;
    int n = 0;
    drive(w, 1'b1, d, sof, ld, md);
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = (w == 0) ? tx_if.in_ready : rx_if.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: lane set %0d never accepted beat %0h", w, d);
    end
    drive(w, 1'b0, d, 1'b0, 1'b0, md);
  endtask

  task automatic drain(input int w);
    int n = 0;
    while (expq[w].size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", 32'(expq[w].size()), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ym;
    logic [W:0]   orig [$];
    logic [W-1:0] d;
    logic         sof;
    logic [W-1:0] first;
    int mm, acc;

    model_clear();
    drive(0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    drive(1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    tx_if.out_ready = 1'b1;
    rx_if.out_ready = 1'b1;

    // Hand-worked vectors pinning the model itself.
    pc_model(0, 1'b1, 0, 8'h39, ym, mm); chk("model_tx_a", 32'(ym), 32'hA5);
    pc_model(0, 1'b1, mm, 8'h55, ym, mm); chk("model_tx_b", 32'(ym), 32'hBB);
    pc_model(1, 1'b1, 0, 8'hA5, ym, mm); chk("model_rx_a", 32'(ym), 32'h39);
    pc_model(1, 1'b1, mm, 8'hBB, ym, mm); chk("model_rx_b", 32'(ym), 32'h55);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(tx_if.out_valid), 32'd0);
    chk("rst_out_data",  32'(tx_if.out_data),  32'd0);
    chk("rst_out_sof",   32'(tx_if.out_sof),   32'd0);
    chk("rst_in_ready",  32'(tx_if.in_ready),  32'd0);
    chk("rst_mode_act",  32'(tx_if.mode_act),  32'd1);
    @(posedge clk); #1 rst = 1'b0;

    // TX precode, one-cycle latency.
    send(0, 8'h39, 1'b1, 1'b0, 1'b0);
    @(negedge clk); chk("tx_sof_valid", 32'(tx_if.out_valid), 32'd1);
    chk("tx_sof_beat", 32'(tx_if.out_data), 32'hA5);
    @(posedge clk); #1;
    send(0, 8'h55, 1'b0, 1'b0, 1'b0);
    @(negedge clk); chk("tx_second_beat", 32'(tx_if.out_data), 32'hBB);
    @(posedge clk); #1;

    // RX decode.
    send(1, 8'hA5, 1'b1, 1'b0, 1'b0);
    @(negedge clk); chk("rx_sof_beat", 32'(rx_if.out_data), 32'h39);
    @(posedge clk); #1;
    send(1, 8'hBB, 1'b0, 1'b0, 1'b0);
    @(negedge clk); chk("rx_second_beat", 32'(rx_if.out_data), 32'h55);
    @(posedge clk); #1;

    // A sof beat clears mem: 0x55 after a fresh frame start gives 0x11.
    send(0, 8'h39, 1'b1, 1'b0, 1'b0);
    send(0, 8'h55, 1'b1, 1'b0, 1'b0);
    @(negedge clk); chk("sof_clears_mem", 32'(tx_if.out_data), 32'h11);
    @(posedge clk); #1;

    // Mode change waits for the next sof.
    send(0, 8'h39, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); chk("mode_held_after_load", 32'(tx_if.mode_act), 32'd1);
    @(posedge clk); #1;
    send(0, 8'h55, 1'b0, 1'b0, 1'b0);
    @(negedge clk); chk("mode_held_midframe", 32'(tx_if.mode_act), 32'd1);
    @(posedge clk); #1;
    send(0, 8'h39, 1'b1, 1'b0, 1'b0);
    @(negedge clk); chk("bypass_beat", 32'(tx_if.out_data), 32'h39);
    chk("bypass_mode_act", 32'(tx_if.mode_act), 32'd0);
    @(posedge clk); #1;
    send(0, 8'h39, 1'b1, 1'b1, 1'b1);
    @(negedge clk); chk("load_on_sof_beat", 32'(tx_if.out_data), 32'hA5);
    chk("load_on_sof_mode", 32'(tx_if.mode_act), 32'd1);
    @(posedge clk); #1;

    // Backpressure: two accepts, then ready falls and the head stays put.
    rmode = 2;
    @(posedge clk); #1;
    drive(0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    acc = 0;
    first = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (tx_if.in_ready) acc++;
      if (k == 1) first = tx_if.out_data;
      if (k > 1) chk("bp_data_stable", 32'(tx_if.out_data), 32'(first));
      @(posedge clk); #1;
    end
    chk("bp_accepts", 32'(acc), 32'd2);
    @(negedge clk); chk("bp_in_ready_low", 32'(tx_if.in_ready), 32'd0);
    @(posedge clk); #1;
    drive(0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    rmode = 0;
    drain(0);

    // Async reset while a stalled beat is held, with bypass active.
    send(0, 8'h39, 1'b1, 1'b1, 1'b0);
    rmode = 2;
    @(posedge clk); #1;
    send(0, 8'h39, 1'b0, 1'b0, 1'b0);
    @(negedge clk); chk("pre_rst_valid", 32'(tx_if.out_valid), 32'd1);
    chk("pre_rst_mode", 32'(tx_if.mode_act), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(tx_if.out_valid), 32'd0);
    chk("async_rst_mode",  32'(tx_if.mode_act),  32'd1);
    chk("async_rst_ready", 32'(tx_if.in_ready),  32'd0);
    @(posedge clk); #1 rst = 1'b0;
    rmode = 0;
    send(0, 8'h39, 1'b1, 1'b0, 1'b0);
    @(negedge clk); chk("post_rst_beat", 32'(tx_if.out_data), 32'hA5);
    @(posedge clk); #1;
    drain(0);

    // Random frames through TX, then TX output through RX must restore the input.
    rmode = 1;
    outs[0].delete();
    outs[1].delete();
    collect = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      d   = W'($urandom);
      sof = (k == 0) || ($urandom_range(0, 7) == 0);
      orig.push_back({sof, d});
      send(0, d, sof, 1'b0, 1'b0);
    end
    drain(0);
    chk("loop_tx_count", 32'(outs[0].size()), 32'd1000);
    for (int k = 0; k < outs[0].size(); k++)
      send(1, outs[0][k][W-1:0], outs[0][k][W], 1'b0, 1'b0);
    drain(1);
    collect = 1'b0;
    chk("loop_rx_count", 32'(outs[1].size()), 32'd1000);
    for (int k = 0; k < outs[1].size() && k < orig.size(); k++)
      chk("loopback_identity", 32'(outs[1][k]), 32'(orig[k]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
